// File: rtl/johnson_pkg.sv
// Shared constants and types for Johnson-code consumers.
package johnson_pkg;

  localparam int JC_W      = 8;
  localparam int JC_STATES = 16;
  localparam int JC_CW     = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } jc_state_t;

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code checker and decoder: code word -> legal flag and state index.
import johnson_pkg::*;

module johnson_code_decode (
  input  logic [JC_W-1:0]  in_code,
  output logic             legal,
  output logic [JC_CW-1:0] count
);

  logic [JC_CW-1:0] ones;
  logic [JC_CW-1:0] edges;

  // Legal codes have at most one bit-to-bit transition; index comes from popcount and the top bit.
  always_comb begin
    ones  = '0;
    edges = '0;
    for (int unsigned i = 0; i < JC_W; i++) begin
      ones = ones + JC_CW'(in_code[i]);
    end
    for (int unsigned i = 0; i < JC_W - 1; i++) begin
      edges = edges + JC_CW'(in_code[i] ^ in_code[i+1]);
    end
    legal = (edges <= JC_CW'(1));
    if (in_code[JC_W-1] || (ones == '0)) begin
      count = ones;
    end else begin
      // 16 - p wraps naturally in 4 bits
      count = '0 - ones;
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson code stream receiver: decode, sequence check, lock FSM and error counter.
import johnson_pkg::*;

module johnson_decoder #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [JC_W-1:0]  in_code,
  input  logic             err_clr,
  output logic             out_valid,
  output logic [JC_CW-1:0] out_count,
  output logic             code_err,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [JC_CW-1:0] LOCK_V = JC_CW'(LOCK_CNT);

  jc_state_t        state;
  logic [JC_CW-1:0] ref_q;
  logic [JC_CW-1:0] run_q;

  logic             legal;
  logic [JC_CW-1:0] count;
  logic [JC_CW-1:0] ref_inc;
  logic [JC_CW-1:0] run_inc;
  logic             in_seq;
  logic             err_event;

  johnson_code_decode u_dec (
    .in_code (in_code),
    .legal   (legal),
    .count   (count)
  );

  // Sequence comparison and error detection for the current sample.
  always_comb begin
    ref_inc   = ref_q + JC_CW'(1);
    run_inc   = run_q + JC_CW'(1);
    in_seq    = (count == ref_inc);
    err_event = in_valid && (!legal || ((state != HUNT) && !in_seq));
  end

  // Lock FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      ref_q     <= '0;
      run_q     <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      code_err  <= 1'b0;
      seq_err   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      code_err  <= 1'b0;
      seq_err   <= 1'b0;
      if (in_valid) begin
        if (!legal) begin
          out_count <= '0;
          code_err  <= 1'b1;
          run_q     <= '0;
          state     <= HUNT;
          locked    <= 1'b0;
        end else begin
          out_count <= count;
          ref_q     <= count;
          case (state)
            HUNT: begin
              run_q  <= '0;
              state  <= CHECK;
              locked <= 1'b0;
            end
            default: begin
              if (!in_seq) begin
                seq_err <= 1'b1;
                run_q   <= '0;
                state   <= CHECK;
                locked  <= 1'b0;
              end else if (state == CHECK) begin
                run_q <= run_inc;
                if (run_inc == LOCK_V) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end
            end
          endcase
        end
      end
    end
  end

  // Saturating error counter; clear wins over a simultaneous increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (err_event && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder: directed vector table, corner sequences, random vs. model.
module tb_johnson_decoder;

  localparam int LOCK_CNT = 4;
  localparam int ERR_W    = 8;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [7:0]       in_code = '0;
  logic             err_clr = 1'b0;
  logic             out_valid;
  logic [3:0]       out_count;
  logic             code_err;
  logic             seq_err;
  logic             locked;
  logic [ERR_W-1:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  johnson_decoder #(.LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .err_clr   (err_clr),
    .out_valid (out_valid),
    .out_count (out_count),
    .code_err  (code_err),
    .seq_err   (seq_err),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] code;
    logic       clr;
    logic       ov;
    int         cnt;
    logic       ce;
    logic       se;
    logic       lk;
    int         ec;
  } vec_t;

  vec_t vecs[$];

  // Legal code for each index: k ones from the top for 0..8, then ones shrinking from the bottom.
  logic [7:0] jc[16];

  // Reference model state
  int m_prev;
  int m_streak;
  bit m_hunt;
  int m_cnt;
  bit m_ce, m_se, m_ov;
  int m_ec;

  task automatic model_reset();
    m_prev = 0; m_streak = 0; m_hunt = 1; m_cnt = 0;
    m_ce = 0; m_se = 0; m_ov = 0; m_ec = 0;
  endtask

  function automatic int lookup(input logic [7:0] c);
    int r;
    r = -1;
    for (int k = 0; k < 16; k++) if (jc[k] == c) r = k;
    return r;
  endfunction

  task automatic model_step(input logic v, input logic [7:0] c, input logic clr);
    int idx;
    m_ov = v; m_ce = 0; m_se = 0;
    if (v) begin
      idx = lookup(c);
      if (idx < 0) begin
        m_ce = 1; m_cnt = 0; m_hunt = 1; m_streak = 0;
      end else begin
        m_cnt = idx;
        if (m_hunt) begin
          m_hunt = 0; m_streak = 0;
        end else if (idx == (m_prev + 1) % 16) begin
          m_streak++;
        end else begin
          m_se = 1; m_streak = 0;
        end
        m_prev = idx;
      end
    end
    if (clr) m_ec = 0;
    else if ((m_ce || m_se) && m_ec < ERR_MAX) m_ec++;
  endtask

  function automatic bit m_locked();
    return !m_hunt && (m_streak >= LOCK_CNT);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input int cnt, input logic ce,
                         input logic se, input logic lk, input int ec);
    chk({tag, ".out_valid"}, int'(out_valid), int'(ov));
    chk({tag, ".out_count"}, int'(out_count), cnt);
    chk({tag, ".code_err"},  int'(code_err),  int'(ce));
    chk({tag, ".seq_err"},   int'(seq_err),   int'(se));
    chk({tag, ".locked"},    int'(locked),    int'(lk));
    chk({tag, ".err_cnt"},   int'(err_cnt),   ec);
  endtask

  // Apply one cycle of input; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic v, input logic [7:0] c, input logic clr);
    in_valid = v; in_code = c; err_clr = clr;
    @(posedge clk);
    #1;
    model_step(v, c, clr);
  endtask

  task automatic add(input logic v, input logic [7:0] c, input logic clr, input int cnt,
                     input logic ce, input logic se, input logic lk, input int ec);
    vec_t t;
    t.v = v; t.code = c; t.clr = clr; t.ov = v; t.cnt = cnt;
    t.ce = ce; t.se = se; t.lk = lk; t.ec = ec;
    vecs.push_back(t);
  endtask

  initial begin
    logic [7:0] ones;
    int         sp;
    ones = 8'hFF;
    for (int k = 0; k <= 8; k++) jc[k] = ~(ones >> k);
    for (int k = 9; k < 16; k++) jc[k] = ones >> (k - 8);
    model_reset();

    // Counter stream up to lock at 4
    add(1, 8'h00, 0, 0, 0, 0, 0, 0);
    add(1, 8'h80, 0, 1, 0, 0, 0, 0);
    add(1, 8'hC0, 0, 2, 0, 0, 0, 0);
    add(1, 8'hE0, 0, 3, 0, 0, 0, 0);
    add(1, 8'hF0, 0, 4, 0, 0, 1, 0);
    // Walk on to 13 while locked
    add(1, 8'hF8, 0, 5, 0, 0, 1, 0);
    add(1, 8'hFC, 0, 6, 0, 0, 1, 0);
    add(1, 8'hFE, 0, 7, 0, 0, 1, 0);
    add(1, 8'hFF, 0, 8, 0, 0, 1, 0);
    add(1, 8'h7F, 0, 9, 0, 0, 1, 0);
    add(1, 8'h3F, 0, 10, 0, 0, 1, 0);
    add(1, 8'h1F, 0, 11, 0, 0, 1, 0);
    add(1, 8'h0F, 0, 12, 0, 0, 1, 0);
    add(1, 8'h07, 0, 13, 0, 0, 1, 0);
    // Wrap 14, 15, 0, 1
    add(1, 8'h03, 0, 14, 0, 0, 1, 0);
    add(1, 8'h01, 0, 15, 0, 0, 1, 0);
    add(1, 8'h00, 0, 0, 0, 0, 1, 0);
    add(1, 8'h80, 0, 1, 0, 0, 1, 0);
    add(1, 8'hC0, 0, 2, 0, 0, 1, 0);
    add(1, 8'hE0, 0, 3, 0, 0, 1, 0);
    // Skip 3 -> 5, relock on 9
    add(1, 8'hF8, 0, 5, 0, 1, 0, 1);
    add(1, 8'hFC, 0, 6, 0, 0, 0, 1);
    add(1, 8'hFE, 0, 7, 0, 0, 0, 1);
    add(1, 8'hFF, 0, 8, 0, 0, 0, 1);
    add(1, 8'h7F, 0, 9, 0, 0, 1, 1);
    // Illegal code while locked, then reseed with no seq_err
    add(1, 8'hA5, 0, 0, 1, 0, 0, 2);
    add(1, 8'h00, 0, 0, 0, 0, 0, 2);
    add(1, 8'h80, 0, 1, 0, 0, 0, 2);
    // Gap of 3 with garbage on the bus
    add(0, 8'hA5, 0, 1, 0, 0, 0, 2);
    add(0, 8'h5A, 0, 1, 0, 0, 0, 2);
    add(0, 8'h80, 0, 1, 0, 0, 0, 2);
    add(1, 8'hC0, 0, 2, 0, 0, 0, 2);
    add(1, 8'hE0, 0, 3, 0, 0, 0, 2);
    add(1, 8'hF0, 0, 4, 0, 0, 1, 2);
    // Gap while locked keeps lock
    add(0, 8'h00, 0, 4, 0, 0, 1, 2);
    add(0, 8'h00, 0, 4, 0, 0, 1, 2);
    add(1, 8'hF8, 1, 5, 0, 0, 1, 0);
    // Repeated sample is out of sequence
    add(1, 8'hF8, 0, 5, 0, 1, 0, 1);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].code, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].cnt, vecs[i].ce,
              vecs[i].se, vecs[i].lk, vecs[i].ec);
    end

    // Asynchronous reset mid-stream, away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1, 8'h3F, 0);
    chk_all("post_rst0", 1, 10, 0, 0, 0, 0);
    drive(1, 8'h1F, 0);
    chk_all("post_rst1", 1, 11, 0, 0, 0, 0);

    // Saturation with 300 illegal samples
    for (int i = 0; i < 300; i++) begin
      drive(1, 8'h55, 0);
      if (i == 254 || i == 299) chk($sformatf("sat%0d", i), int'(err_cnt), 255);
      else if (i < 254) chk($sformatf("sat%0d", i), int'(err_cnt), i + 1);
    end
    drive(1, 8'h55, 1);
    chk_all("clr_vs_err", 1, 0, 1, 0, 0, 0);

    // Randomised stream against the model
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    sp = 0;
    for (int i = 0; i < 3000; i++) begin
      int         r;
      logic       v;
      logic [7:0] c;
      r = $urandom_range(0, 11);
      v = 1'b1;
      c = jc[sp];
      case (r)
        0: v = 1'b0;
        1: c = 8'($urandom);
        2: begin sp = $urandom_range(0, 15); c = jc[sp]; end
        3: c = jc[(sp + 15) % 16];
        default: begin c = jc[sp]; end
      endcase
      if (r >= 4) sp = (sp + 1) % 16;
      drive(v, c, ($urandom_range(0, 29) == 0));
      chk_all($sformatf("rnd%0d", i), m_ov, m_cnt, m_ce, m_se, m_locked(), m_ec);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the 8-bit Johnson counter. It samples an 8-bit Johnson code word and decodes it to a 4-bit state index (0–15). It checks that each code is legal and that successive samples step by +1 modulo 16. A lock state machine and a saturating error counter let downstream logic trust the stream.

## Interface
- LOCK_CNT, 4: consecutive in-sequence samples needed to assert `locked`; legal range 1–15.
- ERR_W, 8: width of `err_cnt`.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  `in_code` is sampled on this cycle's clk edge.
- in_code  input  8  Johnson code word; bit 7 is the shift-in end.
- err_clr  input  1  synchronous clear of `err_cnt`.
- out_valid  output  1  registered copy of `in_valid`.
- out_count  output  4  decoded index of the last sample.
- code_err  output  1  last sample was an illegal code; one-cycle pulse with `out_valid`.
- seq_err  output  1  last sample was legal but not prev+1 mod 16; one-cycle pulse with `out_valid`.
- locked  output  1  stream is in sequence.
- err_cnt  output  ERR_W  saturating count of `code_err` plus `seq_err` events.

## Operation
- **Legal codes (16 total):** the code has at most one i in 0..6 with in_code[i] != in_code[i+1].
  - This covers 1^k0^(8-k) for k = 0..8 and 0^k1^(8-k) for k = 1..7.
- **Decode:**
  - p = popcount(in_code).
  - count = p if in_code[7] = 1 or p = 0.
  - count = 16 − p otherwise.
  - Examples: 0x00→0, 0x80→1, 0xFF→8, 0x7F→9, 0x01→15.
- **Illegal code:** `out_count` = 0, `code_err` = 1, state → HUNT.
- **FSM states:** HUNT, CHECK, LOCKED. Internal registers: ref (4 bits), run (4 bits).
  - **HUNT, legal sample:** ref ← count, run ← 0, → CHECK (LOCKED directly if LOCK_CNT = 1 is not allowed; one good step is still required). No `seq_err` is raised in HUNT.
  - **CHECK, in sequence** (count == ref+1 mod 16): ref ← count, run ← run+1. When run+1 == LOCK_CNT → LOCKED.
  - **CHECK or LOCKED, out of sequence:** `seq_err` = 1, ref ← count, run ← 0, → CHECK.
  - **LOCKED, in sequence:** ref ← count, stay in LOCKED.
  - **Any state, illegal code:** → HUNT.
- `locked` = (state == LOCKED), registered.
- **Repeated sample** (count == ref) counts as out of sequence.
- **Wrap-around:** 15→0 (0x01→0x00) is in sequence.
- **`in_valid` = 0:** FSM, ref, run and outputs other than the pulses hold; `out_valid`, `code_err` and `seq_err` go to 0.
- **err_cnt:**
  - Increments by 1 on `code_err` or `seq_err`; the two are mutually exclusive per sample.
  - Saturates at 2^ERR_W − 1.
  - `err_clr` has priority over a simultaneous increment: the result is 0.

## Timing
- Latency is 1 cycle: a sample taken at edge N appears on all outputs after edge N.
- Throughput is one sample per cycle; there is no backpressure.
- `locked` rises on the same cycle as `out_valid` for the LOCK_CNT-th in-sequence step. It falls on the same cycle as the `code_err` or `seq_err` pulse.
- **Reset values:** `out_valid` = 0, `out_count` = 0, `code_err` = 0, `seq_err` = 0, `locked` = 0, `err_cnt` = 0, state = HUNT, ref = 0, run = 0.
- Reset asserted mid-stream clears everything immediately. The first legal sample after release re-seeds from HUNT.

## Structure
- **Package `johnson_pkg`:**
  - Constants JC_W = 8 and JC_STATES = 16.
  - State enum typedef (HUNT, CHECK, LOCKED).
- **Sub-module `johnson_code_decode`:** combinational; `in_code` → legal and count.
  - Reused by any future Johnson-code consumer.
- Top level holds the FSM, output registers and the error counter.

## Test plan
- **Reset, then counter stream:** reset, then feed 0x00, 0x80, 0xC0, 0xE0, 0xF0 with LOCK_CNT = 4.
  - Required: `out_count` 0, 1, 2, 3, 4, each one cycle later.
  - `locked` rises with count 4; no errors.
- **Wrap:** from lock, feed 0x03, 0x01, 0x00, 0x80.
  - Required: counts 14, 15, 0, 1; `locked` stays 1; `err_cnt` = 0.
- **Illegal code:** while locked, feed 0xA5.
  - Required: `code_err` pulse, `out_count` = 0, `locked` = 0, `err_cnt` = 1.
  - Next 0x00 gives no `seq_err`.
- **Skip:** while locked at count 3, feed 0xF8 (5).
  - Required: `seq_err` pulse, `locked` = 0, `err_cnt` increments.
  - 0xFC, 0xFE, 0xFF, 0x7F then relocks on 9.
- **Gaps and reset:** `in_valid` low for 3 cycles mid-stream.
  - Required: `out_valid` = 0 and no errors; the sequence resumes in sequence.
  - Assert `rst` mid-stream: all outputs 0 immediately.
- **Saturation and clear:** 300 illegal samples with ERR_W = 8.
  - Required: `err_cnt` holds at 255.
  - `err_clr` together with an error gives 0.
